// File: rtl/ac_fan_driver.sv
// AC fan/compressor actuator: soft-ramped fan speed, glitch-free fan PWM and an
// anti-short-cycle compressor lockout. Soft ramp is enabled by AC_FAN_SOFT_RAMP_EN.
module ac_fan_driver #(
  parameter int PWM_PERIOD     = 100,
  parameter int RAMP_CYCLES    = 1000,
  parameter int MIN_OFF_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fan_speed,
  input  logic [7:0] fan_heat,
  output logic       fan_pwm,
  output logic [2:0] speed_applied,
  output logic       busy,
  output logic       compressor_on,
  output logic [7:0] setpoint_out
);

  localparam int PW      = $clog2(PWM_PERIOD + 1);
  localparam int OW      = $clog2(MIN_OFF_CYCLES) + 1;
  localparam int QUARTER = PWM_PERIOD / 4;

  typedef enum logic [1:0] {
    ST_LOCKOUT,
    ST_IDLE,
    ST_ON
  } state_e;

  logic [2:0] tgt;
  logic [2:0] speed_q, speed_d;

  assign tgt = (fan_speed > 3'd4) ? 3'd4 : fan_speed;

`ifdef AC_FAN_SOFT_RAMP_EN
  localparam int RW = $clog2(RAMP_CYCLES) + 1;

  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic          busy_q;

  // The dwell counter survives target changes; direction is picked at each step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    speed_d    = speed_q;
    ramp_cnt_d = '0;
    if (speed_q != tgt) begin
      if (ramp_cnt_q == RW'(RAMP_CYCLES - 1)) begin
        speed_d = (tgt > speed_q) ? speed_q + 3'd1 : speed_q - 3'd1;
      end else begin
        ramp_cnt_d = ramp_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      speed_q    <= '0;
      ramp_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      speed_q    <= speed_d;
      ramp_cnt_q <= ramp_cnt_d;
      busy_q     <= (speed_q != tgt);
    end
  end

  assign busy = busy_q;
`else
  assign speed_d = tgt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      speed_q <= '0;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign busy = 1'b0;
`endif

  assign speed_applied = speed_q;

  // PWM: duty is only reloaded at the period boundary so pulses never glitch.
  logic [PW-1:0] pwm_cnt_q, duty_q;
  logic          pwm_q;
  logic          pwm_last;

  assign pwm_last = (pwm_cnt_q == PW'(PWM_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_last ? '0 : pwm_cnt_q + PW'(1);
      if (pwm_last) begin
        duty_q <= PW'(speed_q) * PW'(QUARTER);
      end
      pwm_q <= (pwm_cnt_q < duty_q);
    end
  end

  assign fan_pwm = pwm_q;

  // Compressor lockout FSM.
  state_e        state_q, state_d;
  logic [OW-1:0] off_cnt_q, off_cnt_d;
  logic [7:0]    setpoint_q, setpoint_d;
  logic          dem;

  assign dem = (speed_q != 3'd0) && (fan_heat != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_LOCKOUT;
      off_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      off_cnt_q <= off_cnt_d;
    end
  end

  // Demand is ignored while locked out; leaving ON restarts the off timer.
  always_comb begin
    state_d   = state_q;
    off_cnt_d = '0;
    case (state_q)
      ST_LOCKOUT: begin
        if (off_cnt_q == OW'(MIN_OFF_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          off_cnt_d = off_cnt_q + OW'(1);
        end
      end
      ST_IDLE: if (dem)  state_d = ST_ON;
      ST_ON:   if (!dem) state_d = ST_LOCKOUT;
      default: state_d = ST_LOCKOUT;
    endcase
  end

  always_comb begin
    compressor_on = (state_q == ST_ON);
    setpoint_d    = (state_d == ST_ON) ? fan_heat : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      setpoint_q <= '0;
    end else begin
      setpoint_q <= setpoint_d;
    end
  end

  assign setpoint_out = setpoint_q;

endmodule
